// File: rtl/cfg_receiver_pkg.sv
// cfg_receiver_pkg: shared definitions for the serial configuration receiver.
// Holds the FSM state encoding and the default configuration word length.
package cfg_receiver_pkg;

  localparam int unsigned CFG_WIDTH_DEFAULT = 33;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/cfg_receiver_sync_2ff.sv
// sync_2ff: two-flop synchronizer bank, synchronous active-high reset to 0.
// Ports:
//   clk   - sampling clock
//   reset - synchronous active-high reset
//   d_i   - asynchronous inputs (Width bits)
//   q_o   - synchronized outputs (Width bits)
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cfg_receiver.sv
// cfg_receiver: receives a CFG_WIDTH-bit configuration word shifted in LSB first
// over cfg_sclk/cfg_data while cfg_en frames the transfer, and commits it to cfg_word.
// Optional macro CFG_RX_SYNC_EN routes cfg_en/cfg_sclk/cfg_data through a 2-FF
// synchronizer; without it the inputs are used directly.
// Ports:
//   clk       - system clock, all logic on rising edge
//   reset     - synchronous active-high reset
//   cfg_en    - transfer frame enable
//   cfg_sclk  - serial bit clock, one bit per rising edge
//   cfg_data  - serial data, LSB first
//   cfg_word  - last committed configuration word
//   cfg_valid - one-cycle pulse after each commit
//   cfg_busy  - high while a frame is being shifted in
//   cfg_error - sticky error for the current or most recent frame
module cfg_receiver
  import cfg_receiver_pkg::*;
#(
  parameter int unsigned          CFG_WIDTH   = CFG_WIDTH_DEFAULT,
  parameter logic [CFG_WIDTH-1:0] CFG_DEFAULT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_en,
  input  logic                 cfg_sclk,
  input  logic                 cfg_data,
  output logic [CFG_WIDTH-1:0] cfg_word,
  output logic                 cfg_valid,
  output logic                 cfg_busy,
  output logic                 cfg_error
);

  localparam int unsigned CntW = $clog2(CFG_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CFG_WIDTH);

  logic en_s, sclk_s, data_s;

`ifdef CFG_RX_SYNC_EN
  logic [2:0] sync_out;

  // Data shares the sclk delay path so each edge sees its own bit.
  sync_2ff #(
    .Width(3)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  ({cfg_en, cfg_sclk, cfg_data}),
    .q_o  (sync_out)
  );

  assign {en_s, sclk_s, data_s} = sync_out;
`else
  assign en_s   = cfg_en;
  assign sclk_s = cfg_sclk;
  assign data_s = cfg_data;
`endif

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
  logic [CFG_WIDTH-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 en_prev_q, sclk_prev_q;

  logic                 en_rise, en_fall, sclk_rise;
  logic [CFG_WIDTH-1:0] shifted;
  logic [CntW-1:0]      cnt_inc;

  assign en_rise   = en_s & ~en_prev_q;
  assign en_fall   = ~en_s & en_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign shifted   = {data_s, shreg_q[CFG_WIDTH-1:1]};
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = 1'b0;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (en_rise) begin
          state_d = StShift;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      StShift: begin
        // An enable fall wins over a coincident sclk rise; that bit is dropped.
        if (en_fall) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (sclk_rise) begin
          shreg_d = shifted;
          cnt_d   = cnt_inc;
          if (cnt_inc == LastCnt) begin
            word_d  = shifted;
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (sclk_rise) error_d = 1'b1;
        if (en_fall)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      word_q      <= CFG_DEFAULT;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      en_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      // Previous samples track in every state so a level already high never looks like an edge.
      en_prev_q   <= en_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cfg_word  = word_q;
  assign cfg_valid = valid_q;
  assign cfg_error = error_q;
  assign cfg_busy  = (state_q == StShift);

endmodule

// File: tb/tb_cfg_receiver.sv
module tb_cfg_receiver;

  localparam int W = 33;
  localparam logic [W-1:0] DEF = 33'h0;
`ifdef CFG_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, cfg_en, cfg_sclk, cfg_data;
  logic [W-1:0] cfg_word;
  logic         cfg_valid, cfg_busy, cfg_error;

  cfg_receiver #(
    .CFG_WIDTH  (W),
    .CFG_DEFAULT(DEF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_sclk (cfg_sclk),
    .cfg_data (cfg_data),
    .cfg_word (cfg_word),
    .cfg_valid(cfg_valid),
    .cfg_busy (cfg_busy),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int valid_total = 0;

  always @(posedge clk) if (cfg_valid === 1'b1) valid_total <= valid_total + 1;

  typedef struct {
    logic [W-1:0] val;
    int           nbits;
    int           extra;
    bit           coinc;
    bit           pre_high;
    logic [W-1:0] exp_word;
    bit           exp_err;
    int           exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one framed transfer and returns the number of cfg_valid pulses it produced.
  task automatic send_frame(input logic [W-1:0] val, input int nbits, input int extra,
                            input bit coinc, input bit pre_high, input int hi, input int lo,
                            output int nvalid);
    int v0;
    v0 = valid_total;
    if (pre_high) begin
      cfg_sclk = 1'b1;
      step(2);
    end
    cfg_en = 1'b1;
    step(4);
    if (pre_high) begin
      cfg_sclk = 1'b0;
      step(4);
    end
    for (int i = 0; i < nbits; i++) begin
      cfg_data = val[i];
      cfg_sclk = 1'b1;
      if (coinc && i == nbits - 1) cfg_en = 1'b0;
      step(hi);
      cfg_sclk = 1'b0;
      step(lo);
      if (i == 0 && !(coinc && nbits == 1)) chk("busy_mid", {63'b0, cfg_busy}, 64'd1);
    end
    step(4);
    if (nbits == W && !coinc) begin
      chk("word_commit", {31'b0, cfg_word}, {31'b0, val});
      chk("busy_done", {63'b0, cfg_busy}, 64'd0);
      chk("err_done", {63'b0, cfg_error}, 64'd0);
    end
    for (int e = 0; e < extra; e++) begin
      cfg_sclk = 1'b1;
      step(hi);
      cfg_sclk = 1'b0;
      step(lo);
      step(4);
      if (e == 0) chk("err_overrun", {63'b0, cfg_error}, 64'd1);
    end
    cfg_en = 1'b0;
    step(4);
    nvalid = valid_total - v0;
  endtask

  vec_t         vecs[5];
  logic [W-1:0] model_word;
  logic [63:0]  r;
  int           nv, n, kind, nbits, extra, hi, lo;
  bit           coinc, exp_err;
  int           exp_v;
  logic [W-1:0] val;

  initial begin
    vecs[0] = '{33'h03C000000, 33, 0, 1'b0, 1'b0, 33'h03C000000, 1'b0, 1};
    vecs[1] = '{33'h1FFFFFFFF, 20, 0, 1'b0, 1'b0, 33'h03C000000, 1'b1, 0};
    vecs[2] = '{33'h155555555, 33, 2, 1'b0, 1'b0, 33'h155555555, 1'b1, 1};
    vecs[3] = '{33'h0AAAAAAAA, 33, 0, 1'b1, 1'b0, 33'h155555555, 1'b1, 0};
    vecs[4] = '{33'h012345678, 33, 0, 1'b0, 1'b1, 33'h012345678, 1'b0, 1};

    reset = 1'b1; cfg_en = 1'b0; cfg_sclk = 1'b0; cfg_data = 1'b0;
    step(3);
    chk("rst_word", {31'b0, cfg_word}, {31'b0, DEF});
    chk("rst_valid", {63'b0, cfg_valid}, 64'd0);
    chk("rst_busy", {63'b0, cfg_busy}, 64'd0);
    chk("rst_error", {63'b0, cfg_error}, 64'd0);
    reset = 1'b0;
    step(2);

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].val, vecs[k].nbits, vecs[k].extra, vecs[k].coinc, vecs[k].pre_high,
                 1, 1, nv);
      chk($sformatf("vec%0d_word", k), {31'b0, cfg_word}, {31'b0, vecs[k].exp_word});
      chk($sformatf("vec%0d_err", k), {63'b0, cfg_error}, {63'b0, vecs[k].exp_err});
      chk($sformatf("vec%0d_valid", k), 64'(nv), 64'(vecs[k].exp_valid));
    end

    // Reset after 10 bits aborts the frame without a commit.
    nv = valid_total;
    cfg_en = 1'b1;
    step(4);
    for (int i = 0; i < 10; i++) begin
      cfg_data = 1'b1; cfg_sclk = 1'b1; step(1);
      cfg_sclk = 1'b0; step(1);
    end
    reset = 1'b1;
    cfg_en = 1'b0;
    step(2);
    reset = 1'b0;
    step(4);
    chk("rstmid_word", {31'b0, cfg_word}, {31'b0, DEF});
    chk("rstmid_busy", {63'b0, cfg_busy}, 64'd0);
    chk("rstmid_err", {63'b0, cfg_error}, 64'd0);
    chk("rstmid_valid", 64'(valid_total - nv), 64'd0);
    send_frame(33'h000000001, W, 0, 1'b0, 1'b0, 1, 1, nv);
    chk("post_rst_word", {31'b0, cfg_word}, 64'd1);
    chk("post_rst_valid", 64'(nv), 64'd1);
    model_word = 33'h000000001;

    // Commit latency from the last sclk rise.
    val = 33'h0F0F0F0F0;
    cfg_en = 1'b1;
    step(4);
    for (int i = 0; i < W - 1; i++) begin
      cfg_data = val[i]; cfg_sclk = 1'b1; step(1);
      cfg_sclk = 1'b0; step(1);
    end
    cfg_data = val[W-1];
    cfg_sclk = 1'b1;
    n = 0;
    while (cfg_valid !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    cfg_sclk = 1'b0;
    step(4);
    chk("lat_word", {31'b0, cfg_word}, {31'b0, val});
    cfg_en = 1'b0;
    step(4);
    model_word = val;

    // Randomized frames against a frame-level model.
    for (int t = 0; t < 20; t++) begin
      r     = {$urandom(), $urandom()};
      val   = r[W-1:0];
      kind  = $urandom_range(0, 3);
      hi    = $urandom_range(1, 2);
      lo    = $urandom_range(1, 2);
      nbits = W;
      extra = 0;
      coinc = 1'b0;
      if (kind == 1) nbits = $urandom_range(1, W - 1);
      if (kind == 2) extra = $urandom_range(1, 3);
      if (kind == 3) coinc = 1'b1;
      if (nbits == W && !coinc) begin
        model_word = val;
        exp_err    = (extra > 0);
        exp_v      = 1;
      end else begin
        exp_err = 1'b1;
        exp_v   = 0;
      end
      send_frame(val, nbits, extra, coinc, 1'b0, hi, lo, nv);
      chk($sformatf("rnd%0d_word", t), {31'b0, cfg_word}, {31'b0, model_word});
      chk($sformatf("rnd%0d_err", t), {63'b0, cfg_error}, {63'b0, exp_err});
      chk($sformatf("rnd%0d_valid", t), 64'(nv), 64'(exp_v));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cfg_receiver.md
CFG_RECEIVER -- requirements
Module: cfg_receiver

Interface
REQ-001 SHALL have parameter CFG_WIDTH, default 33, giving the configuration word length in bits.
REQ-002 SHALL have parameter CFG_DEFAULT, default 33'h0, giving the cfg_word value after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_en, input, 1 bit: transfer frame enable from the external loader.
REQ-006 SHALL have port cfg_sclk, input, 1 bit: serial bit clock; each rising edge carries one bit.
REQ-007 SHALL have port cfg_data, input, 1 bit: serial data, LSB first.
REQ-008 SHALL have port cfg_word, output, CFG_WIDTH bits: the last committed configuration word.
REQ-009 SHALL have port cfg_valid, output, 1 bit: single-cycle pulse on each commit.
REQ-010 SHALL have port cfg_busy, output, 1 bit: high while a frame is in progress (state SHIFT).
REQ-011 SHALL have port cfg_error, output, 1 bit: sticky error for the current or most recent frame.

Function
REQ-012 SHALL run a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE: on a cfg_en rise, SHALL go to SHIFT, clear the bit counter and clear cfg_error.
REQ-014 SHIFT: on each detected cfg_sclk rise, SHALL shift data in as shreg <= {data, shreg[W-1:1]} and increment the counter.
REQ-015 Commit: on the CFG_WIDTH-th bit, on that same clk edge, SHALL load cfg_word <= {data, shreg[W-1:1]} and enter DONE.
REQ-016 cfg_valid SHALL be high exactly for the one cycle after the commit edge.
REQ-017 DONE: cfg_en may stay high indefinitely with no effect, and cfg_word SHALL hold.
REQ-018 DONE: any further cfg_sclk rise SHALL set cfg_error, leave cfg_word unchanged and keep the state in DONE.
REQ-019 DONE: on a cfg_en fall, SHALL go to IDLE.
REQ-020 SHIFT: on a cfg_en fall with the counter below CFG_WIDTH, SHALL set cfg_error, leave cfg_word unchanged and go to IDLE.
REQ-021 SHIFT: a cfg_en fall and a cfg_sclk rise detected in the same cycle SHALL be resolved in favour of the cfg_en fall, and the bit SHALL be discarded.
REQ-022 Edge detection SHALL compare the current sclk sample with the previous one, and the previous sample SHALL be updated in every state.
REQ-023 An sclk level already high when cfg_en rises SHALL NOT count as an edge.
REQ-024 cfg_data SHALL be sampled through the same delay path as cfg_sclk, so that data and clock edge stay aligned.
REQ-025 The counter SHALL be $clog2(CFG_WIDTH+1) bits wide and SHALL never wrap.
REQ-026 cfg_busy SHALL be combinational from the state (state == SHIFT).

Reset
REQ-027 While reset is high, the FSM SHALL go to IDLE and the counter and shreg SHALL go to 0.
REQ-028 While reset is high, cfg_word SHALL go to CFG_DEFAULT, cfg_valid to 0 and cfg_error to 0.
REQ-029 While reset is high, the synchronizer and previous-sample registers SHALL go to 0.
REQ-030 A reset mid-frame SHALL abort the frame with no commit, and the next frame SHALL start only on a fresh cfg_en rise.

Configuration
REQ-031 With macro CFG_RX_SYNC_EN defined, cfg_en, cfg_sclk and cfg_data SHALL each pass through a 2-FF synchronizer.
REQ-032 With CFG_RX_SYNC_EN defined, the shift SHALL occur on the 3rd rising clk edge after cfg_sclk is first sampled high, and cfg_en edges SHALL see the same delay.
REQ-033 Without CFG_RX_SYNC_EN, the inputs SHALL be used directly, and the shift SHALL occur on the 1st rising clk edge that samples cfg_sclk high.
REQ-034 All other behaviour SHALL be identical with and without CFG_RX_SYNC_EN.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings (IDLE=0, SHIFT=1, DONE=2) and CFG_WIDTH_DEFAULT=33; these SHALL NOT be redefined locally.
REQ-036 One sub-module, sync_2ff (parameterised width, reset to 0), SHALL be instantiated only under CFG_RX_SYNC_EN.

Verification
REQ-037 Nominal frame: cfg_en high, 33 bits of 33'h03C000000 sent LSB first with sclk high 1 cycle / low 1 cycle -> cfg_word=33'h03C000000, one cfg_valid pulse, cfg_error=0, cfg_busy low after commit.
REQ-038 Short frame: 20 bits of 33'h1FFFFFFFF, then cfg_en falls -> cfg_error=1, no cfg_valid, cfg_word keeps its previous value.
REQ-039 Overrun: 33 bits of 33'h155555555 followed by 2 extra sclk pulses -> cfg_word=33'h155555555, cfg_error=1 after the 34th edge, single cfg_valid.
REQ-040 Reset mid-frame: reset asserted after 10 bits -> cfg_word=CFG_DEFAULT; a following full frame of 33'h000000001 commits correctly.
REQ-041 Same-cycle edges: cfg_en fall coincident with the 33rd sclk rise -> no commit, cfg_error=1.
REQ-042 Latency: with and without CFG_RX_SYNC_EN, the commit edge SHALL be measured at 3 cycles and 1 cycle respectively after the last sclk rise.
